// File: rtl/spart.sv
// Bus-attached serial transceiver: 4-entry register map, programmable 16x baud
// enable, 8N1 transmitter on txd and receiver on rxd.
module spart #(
  parameter logic [15:0] RESET_DIVISOR = 16'h0000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       iocs,
  input  logic       iorw,
  input  logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  output logic       rda,
  output logic       tbr,
  output logic       txd,
  input  logic       rxd
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  logic        bus_wr, bus_rd;
  logic [7:0]  rd_data;
  logic [15:0] div_q, div_d, cnt_q, cnt_d;
  logic        baud_en;

  state_e      tx_state_q, tx_state_d;
  logic [3:0]  tx_tick_q, tx_tick_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_shift_q, tx_shift_d, tx_buf_q, tx_buf_d;
  logic        tbr_q, tbr_d, tx_load;

  state_e      rx_state_q, rx_state_d;
  logic [3:0]  rx_tick_q, rx_tick_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d, rx_buf_q, rx_buf_d;
  logic        rda_q, rda_d, rx_done;
  logic        rxd_s1_q, rxd_s2_q, rxd_s3_q;

  assign bus_wr = iocs & ~iorw;
  assign bus_rd = iocs & iorw;

  always_comb begin
    rd_data = 8'h00;
    case (ioaddr)
      2'b00: rd_data = rx_buf_q;
      2'b01: rd_data = {6'b0, tbr_q, rda_q};
      2'b10: rd_data = div_q[7:0];
      2'b11: rd_data = div_q[15:8];
      default: rd_data = 8'h00;
    endcase
  end

  assign databus = bus_rd ? rd_data : 8'hzz;

  // Divisor registers and baud down-counter; a high-byte write restarts the count.
  always_comb begin
    div_d   = div_q;
    cnt_d   = cnt_q;
    baud_en = 1'b0;
    if (bus_wr && ioaddr == 2'b10) div_d[7:0] = databus;
    if (bus_wr && ioaddr == 2'b11) begin
      div_d[15:8] = databus;
      cnt_d       = {databus, div_q[7:0]};
    end else if (cnt_q == 16'd0) begin
      if (div_q != 16'd0) begin
        baud_en = 1'b1;
        cnt_d   = div_q;
      end
    end else begin
      cnt_d = cnt_q - 16'd1;
    end
  end

  // Transmitter: tbr=0 means the holding buffer is full and waiting for the FSM.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_tick_d  = tx_tick_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_buf_d   = tx_buf_q;
    tbr_d      = tbr_q;
    tx_load    = 1'b0;
    if (bus_wr && ioaddr == 2'b00 && tbr_q) begin
      tx_buf_d = databus;
      tbr_d    = 1'b0;
    end
    case (tx_state_q)
      IDLE: if (!tbr_q) tx_load = 1'b1;
      START: if (baud_en) begin
        tx_tick_d = tx_tick_q + 4'd1;
        if (tx_tick_q == 4'd15) begin
          tx_state_d = DATA;
          tx_bit_d   = 3'd0;
        end
      end
      DATA: if (baud_en) begin
        tx_tick_d = tx_tick_q + 4'd1;
        if (tx_tick_q == 4'd15) begin
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          tx_bit_d   = tx_bit_q + 3'd1;
          if (tx_bit_q == 3'd7) tx_state_d = STOP;
        end
      end
      STOP: if (baud_en) begin
        tx_tick_d = tx_tick_q + 4'd1;
        if (tx_tick_q == 4'd15) begin
          if (!tbr_q) tx_load = 1'b1;
          else        tx_state_d = IDLE;
        end
      end
      default: tx_state_d = IDLE;
    endcase
    if (tx_load) begin
      tx_shift_d = tx_buf_q;
      tbr_d      = 1'b1;
      tx_state_d = START;
      tx_tick_d  = 4'd0;
    end
  end

  always_comb begin
    case (tx_state_q)
      START:   txd = 1'b0;
      DATA:    txd = tx_shift_q[0];
      default: txd = 1'b1;
    endcase
  end

  // Receiver: start bit re-checked at its midpoint, then every 16 enables.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_tick_d  = rx_tick_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_buf_d   = rx_buf_q;
    rx_done    = 1'b0;
    case (rx_state_q)
      IDLE: if (rxd_s3_q && !rxd_s2_q) begin
        rx_state_d = START;
        rx_tick_d  = 4'd0;
      end
      START: if (baud_en) begin
        rx_tick_d = rx_tick_q + 4'd1;
        if (rx_tick_q == 4'd7) begin
          rx_tick_d  = 4'd0;
          rx_bit_d   = 3'd0;
          rx_state_d = rxd_s2_q ? IDLE : DATA;
        end
      end
      DATA: if (baud_en) begin
        rx_tick_d = rx_tick_q + 4'd1;
        if (rx_tick_q == 4'd15) begin
          rx_shift_d = {rxd_s2_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = STOP;
        end
      end
      STOP: if (baud_en) begin
        rx_tick_d = rx_tick_q + 4'd1;
        if (rx_tick_q == 4'd15) begin
          rx_state_d = IDLE;
          if (rxd_s2_q) begin
            rx_buf_d = rx_shift_q;
            rx_done  = 1'b1;
          end
        end
      end
      default: rx_state_d = IDLE;
    endcase
    rda_d = rda_q;
    if (bus_rd && ioaddr == 2'b00) rda_d = 1'b0;
    if (rx_done) rda_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q      <= RESET_DIVISOR;
      cnt_q      <= RESET_DIVISOR;
      tx_state_q <= IDLE;
      tx_tick_q  <= 4'd0;
      tx_bit_q   <= 3'd0;
      tx_shift_q <= 8'h00;
      tx_buf_q   <= 8'h00;
      tbr_q      <= 1'b1;
      rx_state_q <= IDLE;
      rx_tick_q  <= 4'd0;
      rx_bit_q   <= 3'd0;
      rx_shift_q <= 8'h00;
      rx_buf_q   <= 8'h00;
      rda_q      <= 1'b0;
      rxd_s1_q   <= 1'b1;
      rxd_s2_q   <= 1'b1;
      rxd_s3_q   <= 1'b1;
    end else begin
      div_q      <= div_d;
      cnt_q      <= cnt_d;
      tx_state_q <= tx_state_d;
      tx_tick_q  <= tx_tick_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_buf_q   <= tx_buf_d;
      tbr_q      <= tbr_d;
      rx_state_q <= rx_state_d;
      rx_tick_q  <= rx_tick_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_buf_q   <= rx_buf_d;
      rda_q      <= rda_d;
      rxd_s1_q   <= rxd;
      rxd_s2_q   <= rxd_s1_q;
      rxd_s3_q   <= rxd_s2_q;
    end
  end

  assign rda = rda_q;
  assign tbr = tbr_q;

endmodule

// File: tb/tb_spart.sv
// Directed bench for spart: register access, 8N1 transmit/receive at divisor 3
// (64 clk per bit), receive error cases, overrun, reset mid-frame, divisor 0.
module tb_spart;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       iocs = 1'b0;
  logic       iorw = 1'b0;
  logic [1:0] ioaddr = 2'b00;
  logic       rxd = 1'b1;
  logic       drv_en = 1'b0;
  logic [7:0] drv_data = 8'h00;
  wire  [7:0] databus;
  logic       rda, tbr, txd;

  int errors = 0;
  int checks = 0;

  assign databus = drv_en ? drv_data : 8'hzz;

  spart #(.RESET_DIVISOR(16'h0000)) dut (
    .clk(clk), .rst(rst), .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr),
    .databus(databus), .rda(rda), .tbr(tbr), .txd(txd), .rxd(rxd)
  );

  always #5 clk = ~clk;

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    iocs = 1'b1; iorw = 1'b0; ioaddr = a; drv_data = d; drv_en = 1'b1;
    @(negedge clk);
    iocs = 1'b0; drv_en = 1'b0;
    $display("write addr=%0d data=%02h", a, d);
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk);
    iocs = 1'b1; iorw = 1'b1; ioaddr = a;
    #1 d = databus;
    @(negedge clk);
    iocs = 1'b0; iorw = 1'b0;
    $display("read  addr=%0d data=%02h", a, d);
  endtask

  task automatic rx_send(input logic [7:0] b, input logic stop_bit);
    logic [9:0] frame;
    frame = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd = frame[i];
      repeat (64) @(negedge clk);
    end
    rxd = 1'b1;
    repeat (8) @(negedge clk);
    $display("rx frame byte=%02h stop=%0b", b, stop_bit);
  endtask

  task automatic test_reset();
    logic [7:0] d;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++; if (rda !== 1'b0) begin errors++; $display("FAIL reset_rda got=%b exp=0", rda); end
    checks++; if (tbr !== 1'b1) begin errors++; $display("FAIL reset_tbr got=%b exp=1", tbr); end
    checks++; if (txd !== 1'b1) begin errors++; $display("FAIL reset_txd got=%b exp=1", txd); end
    bus_read(2'b01, d);
    checks++; if (d !== 8'h02) begin errors++; $display("FAIL reset_status got=%02h exp=02", d); end
  endtask

  task automatic test_divisor();
    logic [7:0] d;
    bus_write(2'b10, 8'h03);
    bus_write(2'b11, 8'h00);
    bus_read(2'b10, d);
    checks++; if (d !== 8'h03) begin errors++; $display("FAIL div_lo got=%02h exp=03", d); end
    bus_read(2'b11, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL div_hi got=%02h exp=00", d); end
  endtask

  task automatic test_transmit();
    logic [9:0] exp_frame;
    exp_frame = {1'b1, 8'hA5, 1'b0};
    @(negedge clk);
    iocs = 1'b1; iorw = 1'b0; ioaddr = 2'b00; drv_data = 8'hA5; drv_en = 1'b1;
    @(negedge clk);
    checks++; if (tbr !== 1'b0) begin errors++; $display("FAIL tx_tbr_low got=%b exp=0", tbr); end
    drv_data = 8'hFF;  // held write while tbr=0 must be dropped
    @(negedge clk);
    iocs = 1'b0; drv_en = 1'b0;
    checks++; if (tbr !== 1'b1) begin errors++; $display("FAIL tx_tbr_high got=%b exp=1", tbr); end
    $display("tx write A5 then FF (ignored)");
    repeat (30) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (txd !== exp_frame[i]) begin
        errors++; $display("FAIL tx_bit%0d got=%b exp=%b", i, txd, exp_frame[i]);
      end
      repeat (64) @(negedge clk);
    end
    checks++; if (txd !== 1'b1) begin errors++; $display("FAIL tx_no_second_frame got=%b exp=1", txd); end
    checks++; if (tbr !== 1'b1) begin errors++; $display("FAIL tx_tbr_end got=%b exp=1", tbr); end
  endtask

  task automatic test_receive();
    logic [7:0] d;
    rx_send(8'h3C, 1'b1);
    checks++; if (rda !== 1'b1) begin errors++; $display("FAIL rx_rda_set got=%b exp=1", rda); end
    bus_read(2'b00, d);
    checks++; if (d !== 8'h3C) begin errors++; $display("FAIL rx_data got=%02h exp=3C", d); end
    checks++; if (rda !== 1'b0) begin errors++; $display("FAIL rx_rda_clear got=%b exp=0", rda); end
  endtask

  task automatic test_rx_errors();
    logic [7:0] d;
    @(negedge clk);
    rxd = 1'b0;
    repeat (16) @(negedge clk);
    rxd = 1'b1;
    repeat (100) @(negedge clk);
    $display("rx glitch 16 clk");
    checks++; if (rda !== 1'b0) begin errors++; $display("FAIL rx_glitch_rda got=%b exp=0", rda); end
    rx_send(8'h5A, 1'b0);
    repeat (70) @(negedge clk);
    checks++; if (rda !== 1'b0) begin errors++; $display("FAIL rx_framing_rda got=%b exp=0", rda); end
    bus_read(2'b00, d);
    checks++; if (d !== 8'h3C) begin errors++; $display("FAIL rx_framing_buf got=%02h exp=3C", d); end
  endtask

  task automatic test_overrun();
    logic [7:0] d;
    rx_send(8'h11, 1'b1);
    rx_send(8'h22, 1'b1);
    checks++; if (rda !== 1'b1) begin errors++; $display("FAIL ovr_rda got=%b exp=1", rda); end
    bus_read(2'b00, d);
    checks++; if (d !== 8'h22) begin errors++; $display("FAIL ovr_data got=%02h exp=22", d); end
  endtask

  task automatic test_reset_mid_tx();
    logic [7:0] d;
    bus_write(2'b00, 8'h00);
    repeat (100) @(negedge clk);
    checks++; if (txd !== 1'b0) begin errors++; $display("FAIL midtx_txd_busy got=%b exp=0", txd); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    $display("rst mid transmit");
    checks++; if (txd !== 1'b1) begin errors++; $display("FAIL midtx_txd got=%b exp=1", txd); end
    checks++; if (tbr !== 1'b1) begin errors++; $display("FAIL midtx_tbr got=%b exp=1", tbr); end
    bus_read(2'b10, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL midtx_div_lo got=%02h exp=00", d); end
  endtask

  task automatic test_div_zero_freeze();
    bus_write(2'b00, 8'h55);
    @(negedge clk);
    checks++; if (txd !== 1'b0) begin errors++; $display("FAIL div0_start got=%b exp=0", txd); end
    repeat (300) @(negedge clk);
    checks++; if (txd !== 1'b0) begin errors++; $display("FAIL div0_frozen got=%b exp=0", txd); end
    checks++; if (tbr !== 1'b1) begin errors++; $display("FAIL div0_tbr got=%b exp=1", tbr); end
  endtask

  initial begin
    test_reset();
    test_divisor();
    test_transmit();
    test_receive();
    test_rx_errors();
    test_overrun();
    test_reset_mid_tx();
    test_div_zero_freeze();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
